// File: rtl/fx2_cmd_pkg.sv
// Shared opcodes, payload lengths, control targets and FSM encoding for the FX2 command decoder.
package fx2_cmd_pkg;

  localparam logic [7:0] OP_CTRL  = 8'h01;
  localparam logic [7:0] OP_READ  = 8'h04;
  localparam logic [7:0] OP_WRITE = 8'h05;

  localparam logic [2:0] LEN_CTRL  = 3'd2;
  localparam logic [2:0] LEN_READ  = 3'd2;
  localparam logic [2:0] LEN_WRITE = 3'd6;

  localparam logic [7:0] CTRL_TGT_DET = 8'h01;
  localparam logic [7:0] CTRL_TGT_SEQ = 8'h02;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARGS,
    S_EXEC,
    S_RD_WAIT,
    S_REPLY
  } state_t;

  // Zero marks an opcode the decoder does not understand.
  function automatic logic [2:0] payload_len(input logic [7:0] op);
    case (op)
      OP_CTRL:  payload_len = LEN_CTRL;
      OP_READ:  payload_len = LEN_READ;
      OP_WRITE: payload_len = LEN_WRITE;
      default:  payload_len = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/fx2_reply_serializer.sv
// Serialises a 32-bit read word into 4 bytes, LSB first, on a valid/ready stream.
// The byte is held while ready is low; done_o marks the handshake of the 4th byte.
module fx2_reply_serializer (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic [31:0] word_i,
  output logic [7:0]  data_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        done_o
);

  logic [31:0] word_q;
  logic [1:0]  cnt_q;
  logic        vld_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_q <= 32'h0;
      cnt_q  <= 2'd0;
      vld_q  <= 1'b0;
    end else if (load_i) begin
      word_q <= word_i;
      cnt_q  <= 2'd0;
      vld_q  <= 1'b1;
    end else if (vld_q && ready_i) begin
      word_q <= {8'h00, word_q[31:8]};
      cnt_q  <= cnt_q + 2'd1;
      if (cnt_q == 2'd3) vld_q <= 1'b0;
    end
  end

  assign data_o  = word_q[7:0];
  assign valid_o = vld_q;
  assign done_o  = vld_q && ready_i && (cnt_q == 2'd3);

endmodule

// File: rtl/fx2_cmd_decoder.sv
// Decodes FX2 host command frames into register writes/reads and control strobes,
// serialising read replies back to the bridge; aborts frames that stall mid-payload.
module fx2_cmd_decoder
  import fx2_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        fx2_clk,
  input  logic        reset_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] reg_addr,
  output logic [31:0] reg_wdata,
  output logic        reg_wr,
  output logic        reg_rd,
  input  logic [31:0] reg_rdata,
  output logic [7:0]  ctrl_target,
  output logic [7:0]  ctrl_value,
  output logic        ctrl_stb,
  output logic [7:0]  err_count
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  op_q, op_d;
  logic [2:0]  idx_q, idx_d;
  logic [15:0] tmo_q, tmo_d;
  logic [15:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [7:0]  tgt_q, tgt_d;
  logic [7:0]  val_q, val_d;
  logic        wr_q, wr_d;
  logic        rd_q, rd_d;
  logic        stb_q, stb_d;
  logic [7:0]  err_q, err_d;
  logic        alive_q;
  logic        err_inc;
  logic        in_hs;
  logic        ser_load;
  logic        ser_done;

  assign in_ready = alive_q && (state_q == S_IDLE || state_q == S_ARGS);
  assign in_hs    = in_valid && in_ready;

  always_ff @(posedge fx2_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      op_q    <= 8'h00;
      idx_q   <= 3'd0;
      tmo_q   <= 16'h0;
      addr_q  <= 16'h0;
      wdata_q <= 32'h0;
      tgt_q   <= 8'h00;
      val_q   <= 8'h00;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      stb_q   <= 1'b0;
      err_q   <= 8'h00;
      alive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      tmo_q   <= tmo_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      tgt_q   <= tgt_d;
      val_q   <= val_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      stb_q   <= stb_d;
      err_q   <= err_d;
      alive_q <= 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    idx_d    = idx_q;
    tmo_d    = tmo_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    tgt_d    = tgt_q;
    val_d    = val_q;
    wr_d     = 1'b0;
    rd_d     = 1'b0;
    stb_d    = 1'b0;
    err_inc  = 1'b0;
    ser_load = 1'b0;

    case (state_q)
      S_IDLE: begin
        tmo_d = 16'h0;
        if (in_hs) begin
          if (payload_len(in_data) != 3'd0) begin
            op_d    = in_data;
            idx_d   = 3'd0;
            state_d = S_ARGS;
          end else begin
            err_inc = 1'b1;
          end
        end
      end
      S_ARGS: begin
        if (in_hs) begin
          tmo_d = 16'h0;
          // Fields are little-endian; idx_q is the payload byte position.
          case (op_q)
            OP_WRITE: begin
              case (idx_q)
                3'd0:    addr_d[7:0]    = in_data;
                3'd1:    addr_d[15:8]   = in_data;
                3'd2:    wdata_d[7:0]   = in_data;
                3'd3:    wdata_d[15:8]  = in_data;
                3'd4:    wdata_d[23:16] = in_data;
                default: wdata_d[31:24] = in_data;
              endcase
            end
            OP_READ: begin
              if (idx_q == 3'd0) addr_d[7:0] = in_data;
              else               addr_d[15:8] = in_data;
            end
            default: begin
              if (idx_q == 3'd0) tgt_d = in_data;
              else               val_d = in_data;
            end
          endcase
          if (idx_q == payload_len(op_q) - 3'd1) begin
            state_d = S_EXEC;
            wr_d    = (op_q == OP_WRITE);
            rd_d    = (op_q == OP_READ);
            stb_d   = (op_q == OP_CTRL);
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_IDLE;
          tmo_d   = 16'h0;
          err_inc = 1'b1;
        end else begin
          tmo_d = tmo_q + 16'h1;
        end
      end
      S_EXEC: begin
        state_d = (op_q == OP_READ) ? S_RD_WAIT : S_IDLE;
      end
      S_RD_WAIT: begin
        ser_load = 1'b1;
        state_d  = S_REPLY;
      end
      S_REPLY: begin
        if (ser_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    err_d = (err_inc && err_q != 8'hFF) ? err_q + 8'h01 : err_q;
  end

  fx2_reply_serializer u_reply (
    .clk_i   (fx2_clk),
    .rst_ni  (reset_n),
    .load_i  (ser_load),
    .word_i  (reg_rdata),
    .data_o  (out_data),
    .valid_o (out_valid),
    .ready_i (out_ready),
    .done_o  (ser_done)
  );

  assign reg_addr    = addr_q;
  assign reg_wdata   = wdata_q;
  assign reg_wr      = wr_q;
  assign reg_rd      = rd_q;
  assign ctrl_target = tgt_q;
  assign ctrl_value  = val_q;
  assign ctrl_stb    = stb_q;
  assign err_count   = err_q;

endmodule

// File: tb/tb_fx2_cmd_decoder.sv
// Directed bench for fx2_cmd_decoder with a 16-cycle frame timeout.
module tb_fx2_cmd_decoder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] reg_addr;
  logic [31:0] reg_wdata;
  logic        reg_wr;
  logic        reg_rd;
  logic [31:0] reg_rdata = 32'h0;
  logic [7:0]  ctrl_target;
  logic [7:0]  ctrl_value;
  logic        ctrl_stb;
  logic [7:0]  err_count;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc = 0, wr_cnt = 0, rd_cnt = 0, stb_cnt = 0;
  int wr_cycs[$];

  always #5 clk = ~clk;

  fx2_cmd_decoder #(.TIMEOUT_CYCLES(16)) dut (
    .fx2_clk     (clk),
    .reset_n     (reset_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .reg_addr    (reg_addr),
    .reg_wdata   (reg_wdata),
    .reg_wr      (reg_wr),
    .reg_rd      (reg_rd),
    .reg_rdata   (reg_rdata),
    .ctrl_target (ctrl_target),
    .ctrl_value  (ctrl_value),
    .ctrl_stb    (ctrl_stb),
    .err_count   (err_count)
  );

  always @(negedge clk) begin
    cyc++;
    if (reg_wr) begin wr_cnt++; wr_cycs.push_back(cyc); end
    if (reg_rd) rd_cnt++;
    if (ctrl_stb) stb_cnt++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge right after the byte was taken.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      n_checks++; n_fail++;
      $display("FAIL send_byte: in_ready=%b after 50 cycles, required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b [7], input int len);
    for (int i = 0; i < len; i++) send_byte(b[i]);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(2);
    n_checks++;
    if ({in_ready, out_valid, out_data, reg_addr, reg_wdata, reg_wr, reg_rd,
         ctrl_target, ctrl_value, ctrl_stb, err_count} !== 93'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: addr=%h wdata=%h err=%h rdy=%b, required all 0",
               reg_addr, reg_wdata, err_count, in_ready);
    end
    reset_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_release_rdy: in_ready=%b, required 0", in_ready); end
    tick(1);
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_first_edge_rdy: in_ready=%b, required 1", in_ready); end
  endtask

  task automatic test_write();
    int w0 = wr_cnt;
    send_frame('{8'h05, 8'h04, 8'h00, 8'h00, 8'h00, 8'h40, 8'h02}, 7);
    n_checks++;
    if ({reg_wr, reg_addr, reg_wdata} !== {1'b1, 16'h0004, 32'h02400000}) begin
      n_fail++;
      $display("FAIL write_strobe: wr=%b addr=%h wdata=%h, required 1 0004 02400000", reg_wr, reg_addr, reg_wdata);
    end
    tick(1);
    n_checks++;
    if ({reg_wr, in_ready, reg_addr, reg_wdata} !== {1'b0, 1'b1, 16'h0004, 32'h02400000}) begin
      n_fail++;
      $display("FAIL write_after: wr=%b rdy=%b addr=%h wdata=%h, required 0 1 0004 02400000",
               reg_wr, in_ready, reg_addr, reg_wdata);
    end
    tick(2);
    n_checks++;
    if (wr_cnt - w0 !== 1) begin n_fail++; $display("FAIL write_count: %0d strobes, required 1", wr_cnt - w0); end
  endtask

  task automatic test_back_to_back();
    int n0 = wr_cycs.size();
    send_frame('{8'h05, 8'h10, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00}, 7);
    n_checks++;
    if ({reg_wr, in_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL b2b_exec: wr=%b rdy=%b, required 1 0", reg_wr, in_ready);
    end
    send_frame('{8'h05, 8'h14, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00}, 7);
    n_checks++;
    if ({reg_wr, reg_addr, reg_wdata} !== {1'b1, 16'h0014, 32'h00000002}) begin
      n_fail++;
      $display("FAIL b2b_second: wr=%b addr=%h wdata=%h, required 1 0014 00000002", reg_wr, reg_addr, reg_wdata);
    end
    tick(2);
    n_checks++;
    if (wr_cycs.size() - n0 !== 2 || wr_cycs[n0 + 1] - wr_cycs[n0] !== 8) begin
      n_fail++;
      $display("FAIL b2b_throughput: %0d strobes, spacing %0d, required 2 and 8",
               wr_cycs.size() - n0, (wr_cycs.size() - n0 == 2) ? wr_cycs[n0 + 1] - wr_cycs[n0] : -1);
    end
  endtask

  task automatic test_ctrl();
    int s0 = stb_cnt;
    send_frame('{8'h01, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00}, 3);
    n_checks++;
    if ({ctrl_stb, ctrl_target, ctrl_value, reg_wr} !== {1'b1, 8'h01, 8'h01, 1'b0}) begin
      n_fail++;
      $display("FAIL ctrl_det: stb=%b tgt=%h val=%h wr=%b, required 1 01 01 0", ctrl_stb, ctrl_target, ctrl_value, reg_wr);
    end
    send_frame('{8'h01, 8'h02, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00}, 3);
    n_checks++;
    if ({ctrl_stb, ctrl_target, ctrl_value} !== {1'b1, 8'h02, 8'h01}) begin
      n_fail++;
      $display("FAIL ctrl_seq: stb=%b tgt=%h val=%h, required 1 02 01", ctrl_stb, ctrl_target, ctrl_value);
    end
    tick(2);
    n_checks++;
    if (stb_cnt - s0 !== 2 || ctrl_target !== 8'h02) begin
      n_fail++;
      $display("FAIL ctrl_count: %0d strobes tgt=%h, required 2 02", stb_cnt - s0, ctrl_target);
    end
  endtask

  task automatic test_read();
    logic [7:0] rx [4];
    logic [7:0] held;
    int got = 0, hold_err = 0, r0 = rd_cnt;
    logic ph = 1'b0;
    logic was_stalled = 1'b0;
    send_frame('{8'h04, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3);
    n_checks++;
    if ({reg_rd, reg_addr, out_valid} !== {1'b1, 16'h0010, 1'b0}) begin
      n_fail++;
      $display("FAIL read_strobe: rd=%b addr=%h ov=%b, required 1 0010 0", reg_rd, reg_addr, out_valid);
    end
    reg_rdata = 32'h12345678;
    tick(1);
    reg_rdata = 32'hDEADBEEF;
    n_checks++;
    if ({reg_rd, out_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL read_wait: rd=%b ov=%b, required 0 0", reg_rd, out_valid);
    end
    tick(1);
    reg_rdata = 32'h0BAD0BAD;
    n_checks++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL read_valid_rise: ov=%b, required 1", out_valid); end
    for (int c = 0; c < 40 && got < 4; c++) begin
      if (was_stalled && out_data !== held) hold_err++;
      out_ready = ph;
      ph = ~ph;
      was_stalled = out_valid && !out_ready;
      held = out_data;
      if (out_valid && out_ready) begin
        rx[got] = out_data;
        got++;
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    n_checks++;
    if (got !== 4 || {rx[0], rx[1], rx[2], rx[3]} !== 32'hEFBEADDE) begin
      n_fail++;
      $display("FAIL read_reply: %0d bytes %h %h %h %h, required 4 bytes EF BE AD DE", got, rx[0], rx[1], rx[2], rx[3]);
    end
    n_checks++;
    if (hold_err !== 0) begin n_fail++; $display("FAIL read_hold: %0d changes while stalled, required 0", hold_err); end
    n_checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL read_done: ov=%b rdy=%b, required 0 1", out_valid, in_ready);
    end
    out_ready = 1'b1;
    tick(3);
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || rd_cnt - r0 !== 1) begin
      n_fail++;
      $display("FAIL read_no_extra: ov=%b rd strobes=%0d, required 0 1", out_valid, rd_cnt - r0);
    end
  endtask

  task automatic test_unknown();
    send_byte(8'h07);
    n_checks++;
    if ({err_count, in_ready} !== {8'h01, 1'b1}) begin
      n_fail++;
      $display("FAIL unknown_err: err=%h rdy=%b, required 01 1", err_count, in_ready);
    end
    send_frame('{8'h01, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00}, 3);
    n_checks++;
    if ({ctrl_stb, ctrl_target, ctrl_value, err_count} !== {1'b1, 8'h01, 8'h01, 8'h01}) begin
      n_fail++;
      $display("FAIL unknown_recover: stb=%b tgt=%h val=%h err=%h, required 1 01 01 01",
               ctrl_stb, ctrl_target, ctrl_value, err_count);
    end
    tick(1);
  endtask

  task automatic test_timeout();
    int w0 = wr_cnt;
    send_frame('{8'h05, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 2);
    tick(15);
    n_checks++;
    if (err_count !== 8'h01) begin n_fail++; $display("FAIL timeout_early: err=%h after 15 idle, required 01", err_count); end
    tick(1);
    n_checks++;
    if (err_count !== 8'h02) begin n_fail++; $display("FAIL timeout_abort: err=%h after 16 idle, required 02", err_count); end
    send_frame('{8'h05, 8'h08, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44}, 7);
    n_checks++;
    if ({reg_wr, reg_addr, reg_wdata} !== {1'b1, 16'h0008, 32'h44332211}) begin
      n_fail++;
      $display("FAIL timeout_recover: wr=%b addr=%h wdata=%h, required 1 0008 44332211", reg_wr, reg_addr, reg_wdata);
    end
    tick(2);
    n_checks++;
    if (wr_cnt - w0 !== 1) begin n_fail++; $display("FAIL timeout_wr_count: %0d strobes, required 1", wr_cnt - w0); end
  endtask

  task automatic test_reset_mid_frame();
    int w0 = wr_cnt;
    send_frame('{8'h05, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 4);
    reset_n = 1'b0;
    tick(2);
    n_checks++;
    if ({in_ready, out_valid, reg_addr, reg_wdata, reg_wr, reg_rd, ctrl_target, ctrl_value, ctrl_stb, err_count} !== 85'h0) begin
      n_fail++;
      $display("FAIL midreset_outputs: addr=%h wdata=%h err=%h rdy=%b, required all 0",
               reg_addr, reg_wdata, err_count, in_ready);
    end
    reset_n = 1'b1;
    tick(1);
    send_frame('{8'h05, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12}, 7);
    n_checks++;
    if ({reg_wr, reg_addr, reg_wdata} !== {1'b1, 16'h0002, 32'h12345678}) begin
      n_fail++;
      $display("FAIL midreset_fresh: wr=%b addr=%h wdata=%h, required 1 0002 12345678", reg_wr, reg_addr, reg_wdata);
    end
    tick(2);
    n_checks++;
    if (wr_cnt - w0 !== 1) begin n_fail++; $display("FAIL midreset_wr_count: %0d strobes, required 1", wr_cnt - w0); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_write();
    test_back_to_back();
    test_ctrl();
    test_read();
    test_unknown();
    test_timeout();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
